// File: rtl/usb_rx_decoder_if.sv
// Line-state type and the decoder's CDR-facing / packet-facing bus.
// The decoder sits on the slave side; CDR and packet layer use master.
package types;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;
endpackage

interface usb_rx_decoder_if;
  import types::*;

  d_port_t     d;
  logic        strobe;
  logic        rx_active;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_eop;
  logic        rx_error;

  modport master (
    output d,
    output strobe,
    input  rx_active,
    input  rx_valid,
    input  rx_data,
    input  rx_eop,
    input  rx_error
  );

  modport slave (
    input  d,
    input  strobe,
    output rx_active,
    output rx_valid,
    output rx_data,
    output rx_eop,
    output rx_error
  );
endinterface

// File: rtl/usb_rx_decoder.sv
// Low-speed USB receive decoder: SYNC detect, NRZI decode,
// bit unstuffing, LSB-first byte assembly and EOP detection.
module usb_rx_decoder
  import types::*;
#(
  parameter int SYNC_MIN_EDGES = 3,
  parameter int EOP_SE0_MIN    = 1,
  parameter int IDLE_J_BITS    = 7
) (
  input logic            clk,
  input logic            reset,
  usb_rx_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERROR
  } state_t;

  state_t      state, state_n;
  d_port_t     prev, prev_n;
  logic [2:0]  edge_cnt, edge_n;
  logic [2:0]  ones_cnt, ones_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [2:0]  se0_cnt, se0_n;
  logic [7:0]  j_cnt, j_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_q, data_n;
  logic        active_q, active_n;
  logic        valid_q, valid_n;
  logic        eop_q, eop_n;
  logic        err_q, err_n;

  logic        is_jk;
  logic        nrzi;
  logic        go_err;
  logic [7:0]  shreg_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      prev     <= J;
      edge_cnt <= '0;
      ones_cnt <= '0;
      bit_cnt  <= '0;
      se0_cnt  <= '0;
      j_cnt    <= '0;
      shreg    <= '0;
      data_q   <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      prev     <= prev_n;
      edge_cnt <= edge_n;
      ones_cnt <= ones_n;
      bit_cnt  <= bit_n;
      se0_cnt  <= se0_n;
      j_cnt    <= j_n;
      shreg    <= shreg_n;
      data_q   <= data_n;
      active_q <= active_n;
      valid_q  <= valid_n;
      eop_q    <= eop_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    prev_n   = prev;
    edge_n   = edge_cnt;
    ones_n   = ones_cnt;
    bit_n    = bit_cnt;
    se0_n    = se0_cnt;
    j_n      = j_cnt;
    shreg_n  = shreg;
    data_n   = data_q;
    active_n = active_q;
    valid_n  = 1'b0;
    eop_n    = 1'b0;
    err_n    = 1'b0;
    go_err   = 1'b0;
    is_jk    = (bus.d == J) || (bus.d == K);
    nrzi     = (bus.d == prev);
    shreg_s  = {nrzi, shreg[7:1]};

    if (bus.strobe) begin
      if (is_jk) begin
        prev_n = bus.d;
      end
      if (bus.d == SE1 && state != S_ERROR) begin
        go_err = 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.d == K) begin
              state_n = S_SYNC;
              edge_n  = 3'd1;
            end
          end
          S_SYNC: begin
            if (!is_jk) begin
              state_n = S_IDLE;
            end else if (!nrzi) begin
              edge_n = (edge_cnt == 3'd7) ? edge_cnt
                                          : edge_cnt + 3'd1;
            end else if (bus.d == K &&
                         32'(edge_cnt) >= SYNC_MIN_EDGES) begin
              state_n  = S_DATA;
              active_n = 1'b1;
              ones_n   = 3'd1;
              bit_n    = 3'd0;
            end else begin
              state_n = S_IDLE;
            end
          end
          S_DATA: begin
            if (!is_jk) begin
              // a stuff bit still pending here is legal
              state_n = S_EOP;
              se0_n   = 3'd1;
            end else if (ones_cnt == 3'd6) begin
              if (nrzi) begin
                go_err = 1'b1;
              end else begin
                ones_n = 3'd0;
              end
            end else begin
              shreg_n = shreg_s;
              ones_n  = nrzi ? ones_cnt + 3'd1 : 3'd0;
              bit_n   = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_n  = shreg_s;
                valid_n = 1'b1;
              end
            end
          end
          S_EOP: begin
            unique case (1'b1)
              (bus.d == SE0): begin
                se0_n = (se0_cnt == 3'd7) ? se0_cnt
                                          : se0_cnt + 3'd1;
              end
              (bus.d == J): begin
                if (32'(se0_cnt) >= EOP_SE0_MIN) begin
                  state_n  = S_IDLE;
                  active_n = 1'b0;
                  eop_n    = 1'b1;
                  err_n    = (bit_cnt != 3'd0);
                end else begin
                  go_err = 1'b1;
                end
              end
              default: go_err = 1'b1;
            endcase
          end
          S_ERROR: begin
            if (bus.d == J) begin
              if (32'(j_cnt) >= IDLE_J_BITS - 1) begin
                state_n = S_IDLE;
                j_n     = 8'd0;
              end else begin
                j_n = j_cnt + 8'd1;
              end
            end else begin
              j_n = 8'd0;
            end
          end
          default: state_n = S_IDLE;
        endcase
      end

      if (go_err) begin
        state_n  = S_ERROR;
        active_n = 1'b0;
        err_n    = 1'b1;
        j_n      = 8'd0;
      end
    end
  end

  assign bus.rx_active = active_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_data   = data_q;
  assign bus.rx_eop    = eop_q;
  assign bus.rx_error  = err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: line symbols are hand-built,
// a negedge monitor counts output pulses for each check.
module tb_usb_rx_decoder;
  import types::*;

  logic clk;
  logic reset;
  usb_rx_decoder_if bus ();

  usb_rx_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int nvalid, neop, nerr, nboth, nbad, nact;
  int v0, e0, r0, b0, a0;
  logic [7:0] last_data;
  d_port_t line;

  initial begin
    n_chk = 0; n_fail = 0;
    nvalid = 0; neop = 0; nerr = 0;
    nboth = 0; nbad = 0; nact = 0;
    last_data = 8'h00;
  end

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      nvalid++;
      last_data = bus.rx_data;
    end
    if (bus.rx_eop) neop++;
    if (bus.rx_error) nerr++;
    if (bus.rx_eop && bus.rx_error) nboth++;
    if (bus.rx_eop && bus.rx_valid) nbad++;
    if (bus.rx_active) nact++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0 = nvalid; e0 = neop; r0 = nerr; b0 = nboth; a0 = nact;
  endtask

  task automatic put(input d_port_t s);
    @(negedge clk);
    bus.d = s;
    bus.strobe = 1'b1;
    @(negedge clk);
    bus.strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_sync();
    put(K); put(J); put(K); put(J);
    put(K); put(J); put(K); put(K);
    line = K;
  endtask

  task automatic send_bits(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (!b[i]) line = (line == J) ? K : J;
      put(line);
    end
  endtask

  task automatic send_eop();
    put(SE0); put(SE0); put(J);
    line = J;
  endtask

  task automatic idle_j(input int n);
    for (int i = 0; i < n; i++) put(J);
    line = J;
  endtask

  initial begin
    reset = 1'b1;
    bus.d = J;
    bus.strobe = 1'b0;
    line = J;
    repeat (3) @(negedge clk);
    check("rst_active", 32'(bus.rx_active), 0);
    check("rst_valid", 32'(bus.rx_valid), 0);
    check("rst_eop", 32'(bus.rx_eop), 0);
    check("rst_error", 32'(bus.rx_error), 0);
    check("rst_data", 32'(bus.rx_data), 32'h00);
    reset = 1'b0;

    // 1: idle J line
    snap();
    idle_j(50);
    check("t1_valid", nvalid - v0, 0);
    check("t1_eop", neop - e0, 0);
    check("t1_err", nerr - r0, 0);
    check("t1_active", nact - a0, 0);

    // 2: 0xA5 packet
    snap();
    send_sync();
    check("t2_active", 32'(bus.rx_active), 1);
    send_bits(16'h00A5, 8);
    check("t2_valid", nvalid - v0, 1);
    check("t2_data", 32'(last_data), 32'hA5);
    send_eop();
    check("t2_eop", neop - e0, 1);
    check("t2_err", nerr - r0, 0);
    check("t2_idle", 32'(bus.rx_active), 0);

    // 3: 0xFF with a stuffed zero after the sixth one
    snap();
    send_sync();
    send_bits(16'h01DF, 9);
    check("t3_valid", nvalid - v0, 1);
    check("t3_data", 32'(last_data), 32'hFF);
    send_eop();
    check("t3_eop", neop - e0, 1);
    check("t3_err", nerr - r0, 0);

    // 4: seven ones in a row is a stuff error
    snap();
    send_sync();
    send_bits(16'h001F, 5);
    check("t4_noerr", nerr - r0, 0);
    send_bits(16'h0001, 1);
    check("t4_err", nerr - r0, 1);
    check("t4_active", 32'(bus.rx_active), 0);
    put(K);
    check("t4_once", nerr - r0, 1);
    idle_j(7);
    check("t4_valid", nvalid - v0, 0);
    snap();
    send_sync();
    send_bits(16'h00A5, 8);
    send_eop();
    check("t4_rec_valid", nvalid - v0, 1);
    check("t4_rec_data", 32'(last_data), 32'hA5);
    check("t4_rec_eop", neop - e0, 1);
    check("t4_rec_err", nerr - r0, 0);

    // 5: partial trailing byte
    snap();
    send_sync();
    send_bits(16'h0AAA, 12);
    check("t5_valid", nvalid - v0, 1);
    check("t5_data", 32'(last_data), 32'hAA);
    send_eop();
    check("t5_eop", neop - e0, 1);
    check("t5_err", nerr - r0, 1);
    check("t5_both", nboth - b0, 1);

    // 6: reset mid-packet
    snap();
    send_sync();
    send_bits(16'h000A, 4);
    check("t6_active", 32'(bus.rx_active), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_active", 32'(bus.rx_active), 0);
    check("t6_rst_data", 32'(bus.rx_data), 32'h00);
    reset = 1'b0;
    line = J;
    check("t6_no_pulse", (nvalid - v0) + (neop - e0) + (nerr - r0), 0);
    snap();
    send_sync();
    send_bits(16'h003C, 8);
    send_eop();
    check("t6_valid", nvalid - v0, 1);
    check("t6_data", 32'(last_data), 32'h3C);
    check("t6_eop", neop - e0, 1);
    check("t6_err", nerr - r0, 0);

    // 7: SE1 mid-packet
    snap();
    send_sync();
    send_bits(16'h0005, 3);
    put(SE1);
    check("t7_err", nerr - r0, 1);
    check("t7_active", 32'(bus.rx_active), 0);
    idle_j(7);
    snap();
    send_sync();
    send_bits(16'h005A, 8);
    send_eop();
    check("t7_rec_data", 32'(last_data), 32'h5A);
    check("t7_rec_eop", neop - e0, 1);

    check("valid_eop_excl", nbad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
